// File: rtl/lock_ctrl.sv
// Keypad lock controller: compares an entered 8-bit code against a
// programmable code register and walks IDLE/OPEN/FAIL/LOCKOUT with timed
// dwells.
// Key handshake: a key event is the rising edge of key_pulse, which is
// key_pulse high while its registered copy is low. Holding key_pulse high
// therefore yields exactly one event, and the event takes effect on the
// clock edge that ends the cycle in which it is seen.
module lock_ctrl #(
   parameter logic [7:0] DEFAULT_CODE   = 8'hAF,
   parameter int         MAX_FAIL       = 3,
   parameter int         OPEN_CYCLES    = 24_000_000,
   parameter int         FAIL_CYCLES    = 6_000_000,
   parameter int         LOCKOUT_CYCLES = 120_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_pulse,
   input  logic [7:0] code_in,
   input  logic       prog_en,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b,
   output logic       unlocked,
   output logic [1:0] state,
   output logic [1:0] fail_cnt,
   output logic       prog_done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OPEN    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   // Timers load N-1 so the dwell in each timed state is exactly N cycles.
   localparam logic [27:0] OPEN_LOAD    = 28'(OPEN_CYCLES - 1);
   localparam logic [27:0] FAIL_LOAD    = 28'(FAIL_CYCLES - 1);
   localparam logic [27:0] LOCKOUT_LOAD = 28'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]  MAX_FAIL_W   = 3'(MAX_FAIL);

   state_t      r_state;
   logic [27:0] r_timer;
   logic [7:0]  r_code;
   logic [1:0]  r_fail_cnt;
   logic        r_key_d;

   logic        w_event;
   logic        w_match;
   logic        w_expired;
   logic [2:0]  w_fail_next;

   assign w_event     = key_pulse & ~r_key_d;
   assign w_match     = (code_in == r_code);
   assign w_expired   = (r_timer == 28'd0);
   assign w_fail_next = {1'b0, r_fail_cnt} + 3'd1;

   assign state    = r_state;
   assign fail_cnt = r_fail_cnt;

   // LED/unlocked pattern for a given state, as {led_r, led_g, led_b, unlocked}.
   // LEDs are active low; at most one is lit, none in IDLE.
   function automatic logic [3:0] f_leds(input state_t s);
      case (s)
         ST_IDLE:    f_leds = 4'b1110;
         ST_OPEN:    f_leds = 4'b1011;
         ST_FAIL:    f_leds = 4'b0110;
         ST_LOCKOUT: f_leds = 4'b1100;
         default:    f_leds = 4'b1110;
      endcase
   endfunction

   // Delayed key for edge detection; resets high so a key held through reset is not an event.
   always_ff @(posedge clk) begin
      if (rst) r_key_d <= 1'b1;
      else     r_key_d <= key_pulse;
   end

   // Main FSM: state, timer, code register, fail count and registered outputs together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state                          <= ST_IDLE;
         r_code                           <= DEFAULT_CODE;
         r_fail_cnt                       <= 2'd0;
         r_timer                          <= 28'd0;
         {led_r, led_g, led_b, unlocked}  <= f_leds(ST_IDLE);
         prog_done                        <= 1'b0;
      end else begin
         prog_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_event) begin
                  if (w_match) begin
                     r_state                         <= ST_OPEN;
                     r_fail_cnt                      <= 2'd0;
                     r_timer                         <= OPEN_LOAD;
                     {led_r, led_g, led_b, unlocked} <= f_leds(ST_OPEN);
                  end else if (w_fail_next < MAX_FAIL_W) begin
                     r_state                         <= ST_FAIL;
                     r_fail_cnt                      <= w_fail_next[1:0];
                     r_timer                         <= FAIL_LOAD;
                     {led_r, led_g, led_b, unlocked} <= f_leds(ST_FAIL);
                  end else begin
                     r_state                         <= ST_LOCKOUT;
                     r_fail_cnt                      <= MAX_FAIL_W[1:0];
                     r_timer                         <= LOCKOUT_LOAD;
                     {led_r, led_g, led_b, unlocked} <= f_leds(ST_LOCKOUT);
                  end
               end
            end
            ST_OPEN: begin
               // A key event wins over timer expiry in the same cycle.
               if (w_event) begin
                  if (prog_en) begin
                     r_code    <= code_in;
                     prog_done <= 1'b1;
                     r_timer   <= OPEN_LOAD;
                  end else begin
                     r_state                         <= ST_IDLE;
                     r_timer                         <= 28'd0;
                     {led_r, led_g, led_b, unlocked} <= f_leds(ST_IDLE);
                  end
               end else if (w_expired) begin
                  r_state                         <= ST_IDLE;
                  {led_r, led_g, led_b, unlocked} <= f_leds(ST_IDLE);
               end else begin
                  r_timer <= r_timer - 28'd1;
               end
            end
            ST_FAIL: begin
               // Events are ignored here; the fail count survives into IDLE.
               if (w_expired) begin
                  r_state                         <= ST_IDLE;
                  {led_r, led_g, led_b, unlocked} <= f_leds(ST_IDLE);
               end else begin
                  r_timer <= r_timer - 28'd1;
               end
            end
            ST_LOCKOUT: begin
               // Events are ignored here; serving the lockout clears the fail count.
               if (w_expired) begin
                  r_state                         <= ST_IDLE;
                  r_fail_cnt                      <= 2'd0;
                  {led_r, led_g, led_b, unlocked} <= f_leds(ST_IDLE);
               end else begin
                  r_timer <= r_timer - 28'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with short dwells (OPEN 8, FAIL 4, LOCKOUT 16).
module tb_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_pulse;
   logic [7:0] code_in;
   logic       prog_en;
   logic       led_r, led_g, led_b, unlocked;
   logic [1:0] state;
   logic [1:0] fail_cnt;
   logic       prog_done;

   int passed = 0;
   int total  = 0;

   lock_ctrl #(
      .DEFAULT_CODE   (8'hAF),
      .MAX_FAIL       (3),
      .OPEN_CYCLES    (8),
      .FAIL_CYCLES    (4),
      .LOCKOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_pulse (key_pulse),
      .code_in   (code_in),
      .prog_en   (prog_en),
      .led_r     (led_r),
      .led_g     (led_g),
      .led_b     (led_b),
      .unlocked  (unlocked),
      .state     (state),
      .fail_cnt  (fail_cnt),
      .prog_done (prog_done)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_leds(input string tag, input logic [3:0] exp);
      check(tag, {28'd0, led_r, led_g, led_b, unlocked}, {28'd0, exp});
   endtask

   // One-cycle key event; returns just after the edge that consumed it.
   task automatic press(input logic [7:0] code, input logic prog);
      code_in   = code;
      prog_en   = prog;
      key_pulse = 1'b1;
      tick();
      key_pulse = 1'b0;
      prog_en   = 1'b0;
   endtask

   // Expects n consecutive observations of st (starting now), then IDLE.
   // If poke >= 0, a key event is offered during that observation.
   task automatic dwell(input string tag, input logic [1:0] st, input int n, input int poke);
      for (int i = 0; i < n; i++) begin
         check(tag, {30'd0, state}, {30'd0, st});
         key_pulse = (i == poke);
         tick();
      end
      key_pulse = 1'b0;
      check({tag, "_exit"}, {30'd0, state}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      key_pulse = 1'b0;
      code_in   = 8'h00;
      prog_en   = 1'b0;
      tick(); tick(); tick();

      // Reset state
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_fail", {30'd0, fail_cnt}, 32'd0);
      check_leds("rst_leds", 4'b1110);
      check("rst_prog_done", {31'd0, prog_done}, 32'd0);
      rst = 1'b0;
      tick();

      // V-1: correct default code opens for 8 cycles
      press(8'hAF, 1'b0);
      check_leds("v1_leds_open", 4'b1011);
      dwell("v1_open", 2'd1, 8, -1);
      check_leds("v1_leds_idle", 4'b1110);

      // V-2: three wrong entries, the third locks out
      press(8'h00, 1'b0);
      check("v2_fail1_cnt", {30'd0, fail_cnt}, 32'd1);
      check_leds("v2_fail1_leds", 4'b0110);
      dwell("v2_fail1", 2'd2, 4, -1);
      check("v2_fail1_keep", {30'd0, fail_cnt}, 32'd1);
      press(8'h00, 1'b0);
      check("v2_fail2_cnt", {30'd0, fail_cnt}, 32'd2);
      dwell("v2_fail2", 2'd2, 4, -1);
      press(8'h00, 1'b0);
      check("v2_lock_cnt", {30'd0, fail_cnt}, 32'd3);
      check_leds("v2_lock_leds", 4'b1100);
      code_in = 8'hAF;
      dwell("v2_lock", 2'd3, 16, 5);
      check("v2_lock_clear", {30'd0, fail_cnt}, 32'd0);
      check_leds("v2_idle_leds", 4'b1110);

      // V-3: key held for 5 edges gives a single OPEN entry
      code_in   = 8'hAF;
      key_pulse = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         check("v3_open", {30'd0, state}, 32'd1);
         if (i == 4) key_pulse = 1'b0;
         tick();
      end
      check("v3_exit", {30'd0, state}, 32'd0);
      tick(); tick();
      check("v3_stay_idle", {30'd0, state}, 32'd0);

      // V-4: reprogram in OPEN, dwell restarts, new code takes over
      press(8'hAF, 1'b0);
      tick(); tick(); tick();
      check("v4_open_pre", {30'd0, state}, 32'd1);
      press(8'h3C, 1'b1);
      check("v4_prog_done", {31'd0, prog_done}, 32'd1);
      check("v4_prog_state", {30'd0, state}, 32'd1);
      tick();
      check("v4_prog_done_low", {31'd0, prog_done}, 32'd0);
      dwell("v4_reload", 2'd1, 7, -1);
      press(8'hAF, 1'b0);
      check("v4_old_code", {30'd0, state}, 32'd2);
      check("v4_old_cnt", {30'd0, fail_cnt}, 32'd1);
      code_in = 8'h3C;
      dwell("v4_fail_ignore", 2'd2, 4, 1);
      check("v4_fail_keep", {30'd0, fail_cnt}, 32'd1);
      press(8'h3C, 1'b0);
      check("v4_new_code", {30'd0, state}, 32'd1);
      check("v4_new_cnt", {30'd0, fail_cnt}, 32'd0);

      // V-5: manual relock on the expiry cycle, then at mid-dwell
      for (int i = 0; i < 7; i++) tick();
      check("v5_last_open", {30'd0, state}, 32'd1);
      press(8'hAF, 1'b0);
      check("v5_relock_exp", {30'd0, state}, 32'd0);
      tick();
      check("v5_no_reload", {30'd0, state}, 32'd0);
      press(8'h3C, 1'b0);
      check("v5_open2", {30'd0, state}, 32'd1);
      tick(); tick(); tick();
      press(8'h00, 1'b0);
      check("v5_relock_mid", {30'd0, state}, 32'd0);
      check_leds("v5_relock_leds", 4'b1110);
      tick();
      check("v5_stay_idle", {30'd0, state}, 32'd0);

      // V-6: reprogram, lock out, reset mid-lockout with key held
      press(8'h3C, 1'b0);
      tick();
      press(8'h5A, 1'b1);
      check("v6_prog", {31'd0, prog_done}, 32'd1);
      tick();
      press(8'h5A, 1'b0);
      check("v6_relock", {30'd0, state}, 32'd0);
      tick();
      press(8'h00, 1'b0);
      dwell("v6_fail1", 2'd2, 4, -1);
      press(8'h00, 1'b0);
      dwell("v6_fail2", 2'd2, 4, -1);
      press(8'h00, 1'b0);
      check("v6_lock", {30'd0, state}, 32'd3);
      tick(); tick(); tick(); tick(); tick();
      code_in   = 8'hAF;
      key_pulse = 1'b1;
      rst       = 1'b1;
      tick();
      check("v6_rst_state", {30'd0, state}, 32'd0);
      check("v6_rst_cnt", {30'd0, fail_cnt}, 32'd0);
      check_leds("v6_rst_leds", 4'b1110);
      rst = 1'b0;
      tick();
      check("v6_held_key", {30'd0, state}, 32'd0);
      key_pulse = 1'b0;
      tick();
      press(8'hAF, 1'b0);
      check("v6_default_back", {30'd0, state}, 32'd1);
      check_leds("v6_open_leds", 4'b1011);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
